modulo_n_counter: RTL and testbench

MODULO_N_COUNTER -- requirements
Module: modulo_n_counter

---
 rtl/modulo_n_counter.sv | 115 +++++++++++
 tb/tb_modulo_n_counter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_n_counter.sv
// -----------------------------------------------------------------------------
// modulo_n_counter
//
// Up/down counter cycling through 0..MODULUS-1 with a synchronous, range-checked
// load, a terminal-count flag, a one-cycle wrap pulse and a saturating count of
// wraps since reset.
//
// Parameters
//   WIDTH    - count register width in bits
//   MODULUS  - sequence length; legal range 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk       in   single clock, all state updates on its rising edge
//   reset     in   synchronous active-high reset
//   en        in   count enable
//   up_dn     in   direction: 1 = up, 0 = down
//   load      in   synchronous load strobe (takes priority over en)
//   load_val  in   value to load; values >= MODULUS are rejected
//   Q         out  current count (registered)
//   tc        out  terminal count, combinational from Q and up_dn
//   wrap      out  registered one-cycle pulse after a wrap-around edge
//   load_err  out  registered one-cycle pulse after a rejected load
//   wrap_cnt  out  number of wraps since reset, saturating at all-ones
//
// Edge priority: reset > load > en > hold.
// -----------------------------------------------------------------------------
module modulo_n_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err,
    output logic [WIDTH-1:0] wrap_cnt
);

    // Comparisons run one bit wider than the count so MODULUS = 2**WIDTH
    // is representable and never overflows.
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   LAST_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LAST   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] SAT    = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] wcnt_q, wcnt_d;

    logic [WIDTH:0] q_x;
    logic           at_last;
    logic           at_zero;
    logic           load_ok;
    logic           step_wraps;

    assign q_x     = {1'b0, q_q};
    assign at_last = (q_x == LAST_X);
    assign at_zero = (q_x == '0);
    assign load_ok = ({1'b0, load_val} < MOD_X);

    // A wrap happens only on a genuine count step: load (accepted or not)
    // suppresses counting for that edge.
    assign step_wraps = en && !load && (up_dn ? at_last : at_zero);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        wcnt_d = wcnt_q;
        if (load) begin
            if (load_ok) begin
                q_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                q_d = at_last ? '0 : (q_q + WIDTH'(1));
            end else begin
                q_d = at_zero ? LAST : (q_q - WIDTH'(1));
            end
            wrap_d = step_wraps;
            if (step_wraps && (wcnt_q != SAT)) begin
                wcnt_d = wcnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            wcnt_q <= '0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign Q        = q_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;
    assign wrap_cnt = wcnt_q;
    assign tc       = up_dn ? at_last : at_zero;

endmodule

// File: tb/tb_modulo_n_counter.sv
// -----------------------------------------------------------------------------
// Bench for modulo_n_counter (WIDTH=8, MODULUS=7). A plain arithmetic model
// (modulo arithmetic, min() saturation) tracks the expected state; each task
// drives one scenario and compares the DUT against it inline.
// -----------------------------------------------------------------------------
module tb_modulo_n_counter;

    localparam int W   = 8;
    localparam int MOD = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] Q;
    logic         tc;
    logic         wrap;
    logic         load_err;
    logic [W-1:0] wrap_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    int m_q;
    int m_cnt;
    bit m_wrap;
    bit m_err;

    modulo_n_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .Q        (Q),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    // Set inputs away from the active edge.
    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lv);
        @(negedge clk);
        reset    = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = W'(lv);
    endtask

    // Advance one rising edge, update the model from the inputs seen there,
    // then settle before anything is sampled.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_q = 0; m_wrap = 0; m_err = 0; m_cnt = 0;
        end else if (load) begin
            m_wrap = 0;
            if (int'(load_val) < MOD) begin
                m_q = int'(load_val); m_err = 0;
            end else begin
                m_err = 1;
            end
        end else if (en) begin
            m_err = 0;
            if (up_dn) begin
                m_wrap = (m_q == MOD - 1);
                m_q    = (m_q + 1) % MOD;
            end else begin
                m_wrap = (m_q == 0);
                m_q    = (m_q + MOD - 1) % MOD;
            end
            if (m_wrap) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        end else begin
            m_wrap = 0; m_err = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 1, 0, 0);
        step();
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 1, 3);
        step();
        tests_run++;
        if (Q !== '0) begin tests_failed++; $display("FAIL reset_q: got %0d want 0", Q); end
        tests_run++;
        if (wrap !== 1'b0 || load_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pulses: wrap=%b load_err=%b want 0/0", wrap, load_err);
        end
        tests_run++;
        if (wrap_cnt !== '0) begin tests_failed++; $display("FAIL reset_wcnt: got %0d want 0", wrap_cnt); end
        tests_run++;
        if (tc !== 1'b1) begin tests_failed++; $display("FAIL reset_tc_down: got %b want 1", tc); end
    endtask

    task automatic test_up_count();
        int seq [8] = '{1, 2, 3, 4, 5, 6, 0, 1};
        do_reset();
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            tests_run++;
            if (Q !== W'(seq[i]) || int'(Q) != m_q) begin
                tests_failed++; $display("FAIL up_q[%0d]: got %0d want %0d", i, Q, seq[i]);
            end
            tests_run++;
            if (wrap !== (seq[i] == 0)) begin
                tests_failed++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap, seq[i] == 0);
            end
            tests_run++;
            if (tc !== (seq[i] == 6)) begin
                tests_failed++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, seq[i] == 6);
            end
        end
        tests_run++;
        if (wrap_cnt !== 8'd1) begin tests_failed++; $display("FAIL up_wcnt: got %0d want 1", wrap_cnt); end
    endtask

    task automatic test_down_count();
        int seq [3] = '{6, 5, 4};
        do_reset();
        drive(0, 0, 0, 0, 0);
        #1;
        tests_run++;
        if (tc !== 1'b1) begin tests_failed++; $display("FAIL down_tc_zero: got %b want 1", tc); end
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (Q !== W'(seq[i])) begin
                tests_failed++; $display("FAIL down_q[%0d]: got %0d want %0d", i, Q, seq[i]);
            end
            tests_run++;
            if (wrap !== (i == 0)) begin
                tests_failed++; $display("FAIL down_wrap[%0d]: got %b want %b", i, wrap, i == 0);
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        drive(0, 1, 1, 0, 0);
        step(); step();
        drive(0, 1, 1, 1, 3);
        step();
        tests_run++;
        if (Q !== 8'd3 || wrap !== 1'b0) begin
            tests_failed++; $display("FAIL load_ok: Q=%0d wrap=%b want 3/0", Q, wrap);
        end
        drive(0, 1, 1, 0, 0);
        step();
        tests_run++;
        if (Q !== 8'd4) begin tests_failed++; $display("FAIL load_then_up: got %0d want 4", Q); end
    endtask

    task automatic test_load_err();
        // continues from Q=4
        drive(0, 1, 1, 1, 9);
        step();
        tests_run++;
        if (Q !== 8'd4 || load_err !== 1'b1) begin
            tests_failed++; $display("FAIL load_err_hit: Q=%0d load_err=%b want 4/1", Q, load_err);
        end
        drive(0, 0, 1, 0, 0);
        step();
        tests_run++;
        if (Q !== 8'd4 || load_err !== 1'b0) begin
            tests_failed++; $display("FAIL load_err_clear: Q=%0d load_err=%b want 4/0", Q, load_err);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 18; i++) step();
        tests_run++;
        if (Q !== 8'd4 || wrap_cnt !== 8'd2) begin
            tests_failed++; $display("FAIL prio_setup: Q=%0d wcnt=%0d want 4/2", Q, wrap_cnt);
        end
        drive(1, 1, 1, 1, 5);
        step();
        tests_run++;
        if (Q !== '0 || wrap_cnt !== '0 || wrap !== 1'b0 || load_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_reset: Q=%0d wcnt=%0d wrap=%b err=%b want 0/0/0/0", Q, wrap_cnt, wrap, load_err);
        end
    endtask

    task automatic test_reset_between_edges();
        do_reset();
        drive(0, 1, 1, 0, 0);
        step(); step(); step();
        // pulse reset high and low again entirely between two rising edges
        @(negedge clk);
        reset = 1'b1;
        #2 reset = 1'b0;
        step();
        tests_run++;
        if (Q !== 8'd4 || int'(Q) != m_q) begin
            tests_failed++; $display("FAIL reset_glitch: got %0d want 4", Q);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        int bad    = 0;
        do_reset();
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 260 * MOD; i++) begin
            step();
            if (wrap) pulses++;
            if (int'(Q) != m_q || wrap !== m_wrap || int'(wrap_cnt) != m_cnt) bad++;
        end
        tests_run++;
        if (wrap_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_wcnt: got %0d want 255", wrap_cnt); end
        tests_run++;
        if (pulses != 260) begin tests_failed++; $display("FAIL sat_pulses: got %0d want 260", pulses); end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL sat_track: %0d cycles off model want 0", bad); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9)));
            step();
            tests_run++;
            if (int'(Q) != m_q || wrap !== m_wrap || load_err !== m_err || int'(wrap_cnt) != m_cnt
                || tc !== (up_dn ? (m_q == MOD - 1) : (m_q == 0))) begin
                tests_failed++;
                $display("FAIL random[%0d]: Q=%0d wrap=%b err=%b wcnt=%0d tc=%b want Q=%0d wrap=%b err=%b wcnt=%0d",
                         i, Q, wrap, load_err, wrap_cnt, tc, m_q, m_wrap, m_err, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
        m_q = 0; m_cnt = 0; m_wrap = 0; m_err = 0;
        test_reset();
        test_up_count();
        test_down_count();
        test_load();
        test_load_err();
        test_reset_priority();
        test_reset_between_edges();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
